lab3_pattern_driver: RTL

Initiator for the burst-echo-sum protocol: it drives a burst of 1–5 three-bit values on IN_VALID/INPUT into a downstream accumulator, then captures the OUT_VALID/OUT response stream and checks it. The expected response is each value echoed, zero-extended to 6 bits, followed by their 6-bit sum. Used as a self-checking stimulus block in lab testbenches and on-board bring-up.

---
 rtl/lab3_pattern_driver.sv | 136 +++++++++++++
 1 files changed

// File: rtl/lab3_pattern_driver.sv
// lab3_pattern_driver: burst-echo-sum initiator that drives a 1..5 word burst and checks the echoed response
module lab3_pattern_driver #(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [2:0]  LEN,
    input  logic [14:0] DATA,
    input  logic [5:0]  OUT,
    input  logic        OUT_VALID,
    output logic        IN_VALID,
    output logic [2:0]  INPUT,
    output logic        BUSY,
    output logic        DONE,
    output logic        PASS,
    output logic [2:0]  ERR_CNT,
    output logic        TIMED_OUT
);
    typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_DONE} state_t;
    state_t      state;
    logic [2:0]  len_q, idx, k;
    logic [14:0] data_q;
    logic [5:0]  sum_q, exp_word;
    logic [7:0]  tcnt;
    logic        pend, mism;
    logic [2:0]  send_elem, recv_elem, err_pend, err_final;
    logic [3:0]  missing;

    function automatic logic [2:0] elem(input logic [14:0] d, input logic [2:0] i);
        return i == 3'd0 ? d[2:0] : i == 3'd1 ? d[5:3] : i == 3'd2 ? d[8:6] :
               i == 3'd3 ? d[11:9] : i == 3'd4 ? d[14:12] : 3'd0;
    endfunction

    function automatic logic [2:0] sat(input logic [4:0] v);
        return v > 5'd7 ? 3'd7 : v[2:0];
    endfunction

    // expected response word, mismatch flag and saturated error totals for the current word index
    always_comb begin
        send_elem = elem(data_q, idx);
        recv_elem = elem(data_q, k);
        exp_word  = (k < len_q) ? {3'b000, recv_elem} : sum_q;
        mism      = (k > len_q) || (OUT != exp_word);
        missing   = (k <= len_q) ? ({1'b0, len_q} + 4'd1 - {1'b0, k}) : 4'd0;
        err_pend  = sat({2'b00, ERR_CNT} + {4'b0000, pend});
        err_final = sat({2'b00, ERR_CNT} + {4'b0000, pend} + {1'b0, missing});
    end

    // transaction sequencer: latch request, send burst, await and score the response, report
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            len_q     <= '0;
            data_q    <= '0;
            idx       <= '0;
            k         <= '0;
            sum_q     <= '0;
            tcnt      <= '0;
            pend      <= 1'b0;
            IN_VALID  <= 1'b0;
            INPUT     <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            ERR_CNT   <= '0;
            TIMED_OUT <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START && LEN != 3'd0 && LEN <= 3'd5) begin
                        state     <= S_SEND;
                        len_q     <= LEN;
                        data_q    <= DATA;
                        idx       <= '0;
                        k         <= '0;
                        sum_q     <= '0;
                        tcnt      <= '0;
                        pend      <= 1'b0;
                        BUSY      <= 1'b1;
                        PASS      <= 1'b0;
                        ERR_CNT   <= '0;
                        TIMED_OUT <= 1'b0;
                    end
                end
                S_SEND: begin
                    ERR_CNT <= sat({2'b00, ERR_CNT} + {4'b0000, OUT_VALID});
                    if (idx < len_q) begin
                        IN_VALID <= 1'b1;
                        INPUT    <= send_elem;
                        sum_q    <= sum_q + {3'b000, send_elem};
                        idx      <= idx + 3'd1;
                    end else begin
                        IN_VALID <= 1'b0;
                        INPUT    <= '0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (OUT_VALID) begin
                        pend  <= mism;
                        k     <= 3'd1;
                        state <= S_RECV;
                    end else if (tcnt == 8'(TIMEOUT)) begin
                        TIMED_OUT <= 1'b1;
                        PASS      <= 1'b0;
                        ERR_CNT   <= sat({2'b00, len_q} + 5'd1);
                        DONE      <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                S_RECV: begin
                    if (OUT_VALID) begin
                        ERR_CNT <= err_pend;
                        pend    <= mism;
                        k       <= (k == 3'd7) ? k : k + 3'd1;
                    end else begin
                        ERR_CNT <= err_final;
                        pend    <= 1'b0;
                        PASS    <= (err_final == 3'd0) && !TIMED_OUT;
                        DONE    <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
